// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-buffered UART transmitter.
// The parity helper takes a zero-extended 9-bit word, the widest supported frame.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE   = 0;
  localparam int PAR_ODD    = 1;
  localparam int PAR_EVEN   = 2;
  localparam int DATA_MAX_W = 9;

  // Zero padding does not change the XOR reduction, so one width serves all DATA_W.
  function automatic logic parity_bit(input logic [DATA_MAX_W-1:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage is not cleared; resetting the pointers and count flushes it.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start bit, DATA_W bits LSB first, optional parity,
// STOP_BITS stop bits. A word is popped on the cycle before its start bit appears.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  DATA_W       = 8,
  parameter int  CLKS_PER_BIT = 16,
  parameter int  PARITY       = PAR_NONE,
  parameter int  STOP_BITS    = 1,
  parameter int  FIFO_DEPTH   = 4,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_tx,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int               CLK_W     = $clog2(CLKS_PER_BIT);
  localparam int               IDX_W     = $clog2(DATA_W);
  localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [CLK_W-1:0]  r_clk_cnt;
  logic [CLK_W-1:0]  w_clk_cnt_next;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_bit_idx_next;
  logic              r_stop_cnt;
  logic              w_stop_cnt_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_par;
  logic              w_par_next;
  logic              r_tx_out;
  logic              w_tx_out_next;
  logic              r_busy;
  logic              r_overflow;

  logic              w_bit_end;
  logic              w_pop;
  logic [DATA_W-1:0] w_fifo_rdata;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (start_tx),
    .pop   (w_pop),
    .wdata (tx_data),
    .rdata (w_fifo_rdata),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign tx_out     = r_tx_out;
  assign tx_busy    = r_busy;
  assign tx_ready   = !w_fifo_full;
  assign fifo_count = w_fifo_count;
  assign overflow   = r_overflow;
  assign w_bit_end  = (r_clk_cnt == CLK_LAST);

  always_comb begin
    w_state_next    = r_state;
    w_clk_cnt_next  = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_bit_idx_next  = r_bit_idx;
    w_stop_cnt_next = r_stop_cnt;
    w_shift_next    = r_shift;
    w_par_next      = r_par;
    w_tx_out_next   = r_tx_out;
    w_pop           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_next = '0;
        w_tx_out_next  = 1'b1;
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = w_fifo_rdata;
          w_par_next    = parity_bit(DATA_MAX_W'(w_fifo_rdata), PARITY);
          w_state_next  = ST_START;
          w_tx_out_next = 1'b0;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_bit_idx_next = '0;
          w_tx_out_next  = r_shift[0];
        end
      end

      // The line always shows r_shift[0]; the shift happens at each bit boundary.
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == IDX_LAST) begin
            if (PARITY != PAR_NONE) begin
              w_state_next  = ST_PARITY;
              w_tx_out_next = r_par;
            end else begin
              w_state_next    = ST_STOP;
              w_stop_cnt_next = 1'b0;
              w_tx_out_next   = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_shift_next   = {1'b0, r_shift[DATA_W-1:1]};
            w_tx_out_next  = r_shift[1];
          end
        end
      end

      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next    = ST_STOP;
          w_stop_cnt_next = 1'b0;
          w_tx_out_next   = 1'b1;
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          if (r_stop_cnt == STOP_LAST) begin
            if (!w_fifo_empty) begin
              w_pop         = 1'b1;
              w_shift_next  = w_fifo_rdata;
              w_par_next    = parity_bit(DATA_MAX_W'(w_fifo_rdata), PARITY);
              w_state_next  = ST_START;
              w_tx_out_next = 1'b0;
            end else begin
              w_state_next  = ST_IDLE;
              w_tx_out_next = 1'b1;
            end
          end else begin
            w_stop_cnt_next = r_stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_tx_out_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clk_cnt  <= w_clk_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_shift    <= w_shift_next;
      r_par      <= w_par_next;
      r_tx_out   <= w_tx_out_next;
      r_busy     <= (w_state_next != ST_IDLE);
      if (start_tx && w_fifo_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised successor to the packetizer's UART transmitter. It accepts words from the packetizer FSM through a push handshake into an internal FIFO, then serialises them onto `tx_out` as frames. Data width, baud divisor, parity mode, stop-bit count and buffer depth are all configurable. Queued frames go out back-to-back with no idle gap; FIFO occupancy and overflow are reported.

## Interface
- `DATA_W`, 8: data bits per frame, 5–9.
- `CLKS_PER_BIT`, 16: clock cycles per bit; must be ≥ 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: power of two, ≥ 2.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_tx` in 1: push strobe; `tx_data` is written when `start_tx && tx_ready`.
- `tx_data` in `DATA_W`: word to queue.
- `tx_out` out 1: serial line, idle high.
- `tx_busy` out 1: high while a frame is on the line.
- `tx_ready` out 1: FIFO not full, i.e. count != `FIFO_DEPTH`.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `overflow` out 1: sticky; set by a push while `tx_ready` is low.

## Operation
- Frame format: start bit (0), then data LSB first, then the parity bit if `PARITY` != 0, then `STOP_BITS` stop bits (1).
- Parity:
  - odd: parity bit = ~^data.
  - even: parity bit = ^data.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The word is popped in the same cycle and latched into the shift register.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY, or → STOP when parity is none, after `DATA_W` bit periods.
  - PARITY → STOP after 1 bit period.
  - STOP → START when the FIFO is non-empty at the last cycle of the final stop bit; the pop happens in that cycle. Otherwise STOP → IDLE.
- Bit-cycle counter runs 0..`CLKS_PER_BIT`-1 and wraps. Bit index counter runs 0..`DATA_W`-1. Stop counter runs 0..`STOP_BITS`-1.
- `tx_out` is driven from a register, so it is glitch-free.
- FIFO boundary rules:
  - Push and pop in the same cycle: count unchanged, both succeed.
  - Push while full: rejected even if a pop happens that cycle, data is dropped, `overflow` is set.
  - Pop only occurs when non-empty.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- `overflow` is cleared only by `rst`.

## Timing
- Reset values: `tx_out`=1, `tx_busy`=0, `tx_ready`=1, `fifo_count`=0, `overflow`=0, FSM in IDLE. FIFO contents are flushed.
- Reset mid-frame: on the cycle after `rst` is sampled high, `tx_out`=1 and all queued words are discarded.
- Push at cycle N: `fifo_count` increments at N+1.
- FSM in IDLE: pop at N+1, `tx_out` falls and `tx_busy` rises at N+2. Push-to-start-bit latency is 2 cycles.
- Frame length: (1 + `DATA_W` + (`PARITY`!=0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `tx_busy` is high from the first start-bit cycle through the last stop-bit cycle.
  - Back-to-back frames: `tx_busy` stays high continuously.
  - Otherwise it falls on the cycle after the last stop-bit cycle.
- `tx_ready` and `fifo_count` are combinational from registered state only; there is no input-to-output path.

## Structure
- Package `uart_pkg`: FSM state enum, parity mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`.
- Sub-module `sync_fifo`, parametrised on `WIDTH`/`DEPTH`.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - `rdata` is first-word-fall-through.
- The top level holds the FSM, counters, shift register, parity generation and overflow flag.

## Test plan
- `DATA_W`=8, `CLKS_PER_BIT`=4, no parity, 1 stop bit; push 0xA5 → `tx_out` bits 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles. Start bit falls 2 cycles after the push. `tx_busy` is high for 40 cycles.
- `PARITY`=2 with 0x07 → parity bit 1. `PARITY`=1 with 0x07 → parity bit 0. With `STOP_BITS`=2, the line stays high for 8 cycles before the next start bit.
- Push 0x11, 0x22, 0x33 on consecutive cycles → three frames with no idle gap, `tx_busy` never drops, `fifo_count` sequence 1,1,2,…
- `FIFO_DEPTH`=4, push 6 words on consecutive cycles → the first 5 are accepted (one was popped at cycle 1), the 6th is rejected, `overflow`=1, `tx_ready`=0. Five frames are transmitted in order.
- Assert `rst` during data bit 3 of a frame with 2 words queued → next cycle `tx_out`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0, and nothing further is transmitted.
- `DATA_W`=5, `CLKS_PER_BIT`=2 → frame is 7 bits / 14 cycles, and the upper bits of `tx_data` are ignored.
